// File: rtl/bfly01_sdf_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bfly01_sdf_stage                                              |
// | Purpose  : Radix-2 single-delay-feedback butterfly stage. The first half |
// |            of each 2*DEPTH-vector block is parked in a DEPTH-deep buffer.|
// |            Each second-half vector is then paired with the same-index   |
// |            first-half vector. The sum is emitted at once and the        |
// |            difference is written back to the buffer. After the last     |
// |            pair, the buffer drains the differences in slot order.       |
// | Ports    : clk, rstn (async, active-low)                                 |
// |            valid_in, data_re_in/data_im_in  : NCHAN x IN_W signed lanes |
// |            data_re_out/data_im_out          : NCHAN x OUT_W signed lanes|
// |            valid_out, sop_out, is_diff_out  : registered output flags   |
// | Options  : BFLY01_NEG_J_EN - rotate upper-half differences by -j         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bfly01_sdf_stage #(
  parameter int IN_W  = 11,
  parameter int OUT_W = IN_W + 1,
  parameter int NCHAN = 16,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   valid_in,
  input  logic [NCHAN*IN_W-1:0]  data_re_in,
  input  logic [NCHAN*IN_W-1:0]  data_im_in,
  output logic [NCHAN*OUT_W-1:0] data_re_out,
  output logic [NCHAN*OUT_W-1:0] data_im_out,
  output logic                   valid_out,
  output logic                   sop_out,
  output logic                   is_diff_out
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [0:0]       PH_FILL  = 1'b0;
  localparam logic [0:0]       PH_PAIR  = 1'b1;

  // control state
  logic [0:0]       phase_q, phase_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] dr_ptr_q, dr_ptr_d;
  logic             drain_pend_q, drain_pend_d;

  // registered outputs
  logic [NCHAN*OUT_W-1:0] data_re_q, data_re_d;
  logic [NCHAN*OUT_W-1:0] data_im_q, data_im_d;
  logic                   valid_q, valid_d;
  logic                   sop_q, sop_d;
  logic                   is_diff_q, is_diff_d;

  // delay buffer (not reset; contents are meaningless until written)
  logic [OUT_W-1:0] buf_re_q [DEPTH][NCHAN];
  logic [OUT_W-1:0] buf_im_q [DEPTH][NCHAN];

  // datapath wires
  logic [OUT_W-1:0] x2_re [NCHAN];
  logic [OUT_W-1:0] x2_im [NCHAN];
  logic [OUT_W-1:0] x1_re [NCHAN];
  logic [OUT_W-1:0] x1_im [NCHAN];
  logic [OUT_W-1:0] dr_re [NCHAN];
  logic [OUT_W-1:0] dr_im [NCHAN];
  logic [OUT_W-1:0] wr_re [NCHAN];
  logic [OUT_W-1:0] wr_im [NCHAN];
  logic             buf_we;
  logic             pair_fire;

  assign pair_fire = valid_in && (phase_q == PH_PAIR);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_q      <= PH_FILL;
      wr_ptr_q     <= '0;
      dr_ptr_q     <= '0;
      drain_pend_q <= 1'b0;
      data_re_q    <= '0;
      data_im_q    <= '0;
      valid_q      <= 1'b0;
      sop_q        <= 1'b0;
      is_diff_q    <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      wr_ptr_q     <= wr_ptr_d;
      dr_ptr_q     <= dr_ptr_d;
      drain_pend_q <= drain_pend_d;
      data_re_q    <= data_re_d;
      data_im_q    <= data_im_d;
      valid_q      <= valid_d;
      sop_q        <= sop_d;
      is_diff_q    <= is_diff_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      for (int i = 0; i < NCHAN; i++) begin
        buf_re_q[wr_ptr_q][i] <= wr_re[i];
        buf_im_q[wr_ptr_q][i] <= wr_im[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    phase_d      = phase_q;
    wr_ptr_d     = wr_ptr_q;
    dr_ptr_d     = dr_ptr_q;
    drain_pend_d = drain_pend_q;

    // The drain runs every cycle regardless of valid_in.
    if (drain_pend_q) begin
      dr_ptr_d = dr_ptr_q + 1'b1;
      if (dr_ptr_q == PTR_LAST) begin
        drain_pend_d = 1'b0;
      end
    end

    if (valid_in) begin
      if (wr_ptr_q == PTR_LAST) begin
        wr_ptr_d = '0;
        if (phase_q == PH_FILL) begin
          phase_d = PH_PAIR;
        end else begin
          phase_d      = PH_FILL;
          drain_pend_d = 1'b1;
          dr_ptr_d     = '0;
        end
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Datapath and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NCHAN; i++) begin
      x2_re[i] = {{(OUT_W-IN_W){data_re_in[i*IN_W+IN_W-1]}}, data_re_in[i*IN_W +: IN_W]};
      x2_im[i] = {{(OUT_W-IN_W){data_im_in[i*IN_W+IN_W-1]}}, data_im_in[i*IN_W +: IN_W]};
      x1_re[i] = buf_re_q[wr_ptr_q][i];
      x1_im[i] = buf_im_q[wr_ptr_q][i];
`ifdef BFLY01_NEG_J_EN
      // DEPTH is a power of two, so the pointer MSB marks the upper half.
      if (dr_ptr_q[PTR_W-1]) begin
        dr_re[i] = buf_im_q[dr_ptr_q][i];
        dr_im[i] = -buf_re_q[dr_ptr_q][i];
      end else begin
        dr_re[i] = buf_re_q[dr_ptr_q][i];
        dr_im[i] = buf_im_q[dr_ptr_q][i];
      end
`else
      dr_re[i] = buf_re_q[dr_ptr_q][i];
      dr_im[i] = buf_im_q[dr_ptr_q][i];
`endif
    end
  end

  always_comb begin
    buf_we    = valid_in;
    data_re_d = data_re_q;
    data_im_d = data_im_q;
    valid_d   = 1'b0;
    sop_d     = 1'b0;
    is_diff_d = 1'b0;

    // Two's-complement add/sub at OUT_W is exact here: operands are
    // sign-extended IN_W values, so no truncation ever occurs.
    for (int i = 0; i < NCHAN; i++) begin
      if (phase_q == PH_FILL) begin
        wr_re[i] = x2_re[i];
        wr_im[i] = x2_im[i];
      end else begin
        wr_re[i] = x1_re[i] - x2_re[i];
        wr_im[i] = x1_im[i] - x2_im[i];
      end
    end

    if (pair_fire) begin
      valid_d = 1'b1;
      sop_d   = (wr_ptr_q == '0);
      for (int i = 0; i < NCHAN; i++) begin
        data_re_d[i*OUT_W +: OUT_W] = x1_re[i] + x2_re[i];
        data_im_d[i*OUT_W +: OUT_W] = x1_im[i] + x2_im[i];
      end
    end else if (drain_pend_q) begin
      // A same-slot FILL write lands at the clock edge, after this read.
      valid_d   = 1'b1;
      is_diff_d = 1'b1;
      for (int i = 0; i < NCHAN; i++) begin
        data_re_d[i*OUT_W +: OUT_W] = dr_re[i];
        data_im_d[i*OUT_W +: OUT_W] = dr_im[i];
      end
    end
  end

  assign data_re_out = data_re_q;
  assign data_im_out = data_im_q;
  assign valid_out   = valid_q;
  assign sop_out     = sop_q;
  assign is_diff_out = is_diff_q;

`ifndef SYNTHESIS
  // PAIR needs a complete FILL, which takes as long as a full drain, so a
  // sum and a drained difference competing for the output means broken
  // pointer bookkeeping.
  a_no_sum_drain_overlap : assert property (
    @(posedge clk) disable iff (!rstn) !(pair_fire && drain_pend_q)
  );
`endif

endmodule
`default_nettype wire
